// File: rtl/crc_pkg.sv
// Shared widths, FSM state encoding and mode constants for the frame-level CRC engine.
package crc_pkg;

    localparam int CRC_WCODE     = 4;
    localparam int CRC_WPOLY     = 3;
    localparam int CRC_MAX_BEATS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } crc_state_t;

    localparam logic CRC_GEN = 1'b0;
    localparam logic CRC_CHK = 1'b1;

endpackage

// File: rtl/crc_beat_step.sv
// One data beat of the MSB-first CRC shift register, unrolled over every bit of the beat.
module crc_beat_step
    import crc_pkg::*;
#(
    parameter int WCODE = CRC_WCODE,
    parameter int WPOLY = CRC_WPOLY
) (
    input  logic [WPOLY-2:0] rem,
    input  logic [WCODE-1:0] data,
    input  logic [WPOLY-2:0] poly,
    output logic [WPOLY-2:0] next_rem
);

    logic [WPOLY-2:0] rem_s;
    logic             fb_s;

    // Shift each data bit in MSB first; the implicit top poly bit never needs storing.
    always_comb begin
        rem_s = rem;
        fb_s  = 1'b0;
        for (int i = WCODE - 1; i >= 0; i--) begin
            fb_s  = rem_s[WPOLY-2] ^ data[i];
            rem_s = (rem_s << 1) ^ (fb_s ? poly : {(WPOLY-1){1'b0}});
        end
        next_rem = rem_s;
    end

endmodule

// File: rtl/crc_frame_engine.sv
// Frame-level CRC engine: accumulates beats over valid/ready and reports generate/check
// results through a held valid/ready output stage.
module crc_frame_engine
    import crc_pkg::*;
#(
    parameter int WCODE     = CRC_WCODE,
    parameter int WPOLY     = CRC_WPOLY,
    parameter int MAX_BEATS = CRC_MAX_BEATS
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [WCODE-1:0]               i_data,
    input  logic                           i_last,
    input  logic                           i_mode,
    input  logic [WPOLY-1:0]               i_poly,
    input  logic [WPOLY-2:0]               i_init,
    input  logic [WPOLY-2:0]               i_crc_rx,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [WPOLY-2:0]               o_crc,
    output logic                           o_err,
    output logic                           o_ovf,
    output logic [$clog2(MAX_BEATS+1)-1:0] o_beats
);

    localparam int               CW      = WPOLY - 1;
    localparam int               BW      = $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0]    MAX_CNT = BW'(MAX_BEATS);
    localparam logic [BW-1:0]    ONE_CNT = BW'(1);

    crc_state_t       state_r;
    logic             mode_r;
    logic [CW-1:0]    poly_r;
    logic [CW-1:0]    rem_r;
    logic [BW-1:0]    count_r;
    logic             ready_r;
    logic             valid_r;
    logic [CW-1:0]    crc_r;
    logic             err_r;
    logic             ovf_r;
    logic [BW-1:0]    beats_r;

    logic [CW-1:0]    seed_s;
    logic [CW-1:0]    poly_s;
    logic             mode_s;
    logic [BW-1:0]    cnt_next_s;
    logic [CW-1:0]    step_s;
    logic             beat_ok_s;
    logic             end_s;
    logic             cut_s;
    logic             err_s;
    logic             unused_poly_msb_s;

    assign unused_poly_msb_s = i_poly[WPOLY-1];

    crc_beat_step #(
        .WCODE (WCODE),
        .WPOLY (WPOLY)
    ) u_step (
        .rem      (seed_s),
        .data     (i_data),
        .poly     (poly_s),
        .next_rem (step_s)
    );

    // Frame-start beats take mode/poly/init from the ports; later beats use the latched copies.
    always_comb begin
        seed_s     = rem_r;
        poly_s     = poly_r;
        mode_s     = mode_r;
        cnt_next_s = count_r + ONE_CNT;
        if (state_r == IDLE) begin
            seed_s     = i_init;
            poly_s     = i_poly[WPOLY-2:0];
            mode_s     = i_mode;
            cnt_next_s = ONE_CNT;
        end else begin
            seed_s     = rem_r;
            poly_s     = poly_r;
            mode_s     = mode_r;
            cnt_next_s = count_r + ONE_CNT;
        end
        beat_ok_s = i_valid && ready_r;
        cut_s     = (cnt_next_s == MAX_CNT) && !i_last;
        end_s     = i_last || (cnt_next_s == MAX_CNT);
        if (mode_s == CRC_CHK) begin
            err_s = cut_s || (step_s != i_crc_rx);
        end else begin
            err_s = 1'b0;
        end
    end

    // Frame FSM with all handshake and result outputs registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            mode_r  <= CRC_GEN;
            poly_r  <= {CW{1'b0}};
            rem_r   <= {CW{1'b0}};
            count_r <= {BW{1'b0}};
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            crc_r   <= {CW{1'b0}};
            err_r   <= 1'b0;
            ovf_r   <= 1'b0;
            beats_r <= {BW{1'b0}};
        end else begin
            case (state_r)
                IDLE, ACC: begin
                    if (beat_ok_s) begin
                        mode_r  <= mode_s;
                        poly_r  <= poly_s;
                        rem_r   <= step_s;
                        count_r <= cnt_next_s;
                        if (end_s) begin
                            state_r <= DONE;
                            ready_r <= 1'b0;
                            valid_r <= 1'b1;
                            crc_r   <= step_s;
                            err_r   <= err_s;
                            ovf_r   <= cut_s;
                            beats_r <= cnt_next_s;
                        end else begin
                            state_r <= ACC;
                        end
                    end
                end
                DONE: begin
                    // Handoff cycle accepts no beat, giving the mandatory inter-frame bubble.
                    if (i_ready) begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                        valid_r <= 1'b0;
                        rem_r   <= {CW{1'b0}};
                        count_r <= {BW{1'b0}};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = ready_r;
    assign o_valid = valid_r;
    assign o_crc   = crc_r;
    assign o_err   = err_r;
    assign o_ovf   = ovf_r;
    assign o_beats = beats_r;

endmodule

// File: tb/tb_crc_frame_engine.sv
// Scoreboard bench for crc_frame_engine: expected results come from GF(2) long division
// of the init-seeded message, checked by an independent output monitor.
module tb_crc_frame_engine;
    import crc_pkg::*;

    localparam int WCODE = CRC_WCODE;
    localparam int WPOLY = CRC_WPOLY;
    localparam int MAXB  = CRC_MAX_BEATS;
    localparam int BW    = $clog2(MAXB + 1);

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WCODE-1:0] i_data;
    logic             i_last;
    logic             i_mode;
    logic [WPOLY-1:0] i_poly;
    logic [WPOLY-2:0] i_init;
    logic [WPOLY-2:0] i_crc_rx;
    logic             o_valid;
    logic             i_ready;
    logic [WPOLY-2:0] o_crc;
    logic             o_err;
    logic             o_ovf;
    logic [BW-1:0]    o_beats;

    typedef struct packed {
        logic [WPOLY-2:0] crc;
        logic             err;
        logic             ovf;
        logic [BW-1:0]    beats;
    } exp_t;

    exp_t             exp_q[$];
    logic [WCODE-1:0] fdata [0:MAXB-1];
    int               n_checks = 0;
    int               n_fail   = 0;
    bit               hold_ready = 1'b0;
    bit               mon_en     = 1'b0;

    always #5 i_clk = ~i_clk;

    crc_frame_engine dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .i_last   (i_last),
        .i_mode   (i_mode),
        .i_poly   (i_poly),
        .i_init   (i_init),
        .i_crc_rx (i_crc_rx),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_crc    (o_crc),
        .o_err    (o_err),
        .o_ovf    (o_ovf),
        .o_beats  (o_beats)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Remainder of (message with init folded into its first bits) * x^k divided by poly.
    function automatic logic [WPOLY-2:0] ref_crc(input int n, input logic [WPOLY-1:0] poly,
                                                 input logic [WPOLY-2:0] init);
        bit b[$];
        int k;
        logic [WPOLY-2:0] r;
        k = WPOLY - 1;
        for (int i = 0; i < n; i++)
            for (int j = WCODE - 1; j >= 0; j--) b.push_back(fdata[i][j]);
        for (int j = 0; j < k; j++) b.push_back(1'b0);
        for (int j = 0; j < k; j++) b[j] = b[j] ^ init[k-1-j];
        for (int i = 0; i < b.size() - k; i++) begin
            if (b[i]) begin
                b[i] = 1'b0;
                for (int j = 1; j <= k; j++) b[i+j] = b[i+j] ^ poly[k-j];
            end
        end
        for (int j = 0; j < k; j++) r[k-1-j] = b[b.size()-k+j];
        return r;
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!o_ready && t < 200) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        check("ready_wait", o_ready, 1);
    endtask

    task automatic run_frame(input int n, input logic mode, input logic [WPOLY-1:0] poly,
                             input logic [WPOLY-2:0] init, input bit good_rx,
                             input bit with_last, input int gap);
        exp_t e;
        logic [WPOLY-2:0] rx;
        e.crc   = ref_crc(n, poly, init);
        e.ovf   = !with_last;
        e.beats = BW'(n);
        rx      = good_rx ? e.crc : (e.crc ^ (WPOLY-1)'($urandom_range(1, 3)));
        e.err   = (mode == CRC_CHK) ? (e.ovf ? 1'b1 : (rx != e.crc)) : 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            wait_ready();
            i_valid  = 1'b1;
            i_data   = fdata[i];
            i_last   = with_last && (i == n - 1);
            i_mode   = (i == 0) ? mode : 1'($urandom);
            i_poly   = (i == 0) ? poly : WPOLY'($urandom);
            i_init   = (i == 0) ? init : (WPOLY-1)'($urandom);
            i_crc_rx = (i == n - 1) ? rx : (WPOLY-1)'($urandom);
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
            i_last  = 1'b0;
            if (i < n - 1) repeat (gap) begin
                @(posedge i_clk);
                #1;
            end
        end
    endtask

    // Consumer: random acceptance unless the bench is forcing backpressure.
    initial begin
        i_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            i_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every valid cycle must match the scoreboard head; pop on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (mon_en && o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", o_valid, 0);
                end else begin
                    e = exp_q[0];
                    check("crc", o_crc, e.crc);
                    check("err", o_err, e.err);
                    check("ovf", o_ovf, e.ovf);
                    check("beats", o_beats, e.beats);
                    check("ready_in_done", o_ready, 0);
                    if (i_ready) e = exp_q.pop_front();
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_mode = 1'b0;
        i_poly = '0; i_init = '0; i_crc_rx = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_valid", o_valid, 0);
        check("rst_crc", o_crc, 0);
        check("rst_err", o_err, 0);
        check("rst_ovf", o_ovf, 0);
        check("rst_beats", o_beats, 0);
        check("rst_ready", o_ready, 1);
        mon_en = 1'b1;
        @(posedge i_clk);
        #1;

        // Directed generate frames, with and without a mid-frame stall.
        fdata[0] = 4'b1011;
        fdata[1] = 4'b0000;
        run_frame(1, CRC_GEN, 3'b111, 2'b00, 1'b1, 1'b1, 0);
        run_frame(2, CRC_GEN, 3'b111, 2'b00, 1'b1, 1'b1, 0);
        run_frame(2, CRC_GEN, 3'b111, 2'b00, 1'b1, 1'b1, 1);
        // Check mode: matching and mismatching received CRC.
        run_frame(1, CRC_CHK, 3'b111, 2'b00, 1'b1, 1'b1, 0);
        run_frame(1, CRC_CHK, 3'b111, 2'b00, 1'b0, 1'b1, 0);

        // Backpressure: result held for several cycles.
        wait_ready();
        hold_ready = 1'b1;
        run_frame(1, CRC_GEN, 3'b111, 2'b00, 1'b1, 1'b1, 0);
        repeat (5) @(posedge i_clk);
        #1;
        check("bp_valid_held", o_valid, 1);
        hold_ready = 1'b0;
        run_frame(2, CRC_GEN, 3'b111, 2'b00, 1'b1, 1'b1, 0);

        // Overflow: MAX_BEATS beats with no last, in check mode, then a fresh frame.
        for (int i = 0; i < MAXB; i++) fdata[i] = 4'b0001;
        run_frame(MAXB, CRC_CHK, 3'b111, 2'b01, 1'b1, 1'b0, 0);
        fdata[0] = 4'b1011;
        run_frame(1, CRC_GEN, 3'b111, 2'b00, 1'b1, 1'b1, 0);

        // Reset mid-frame: two beats then reset, no result may appear.
        wait_ready();
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        for (int i = 0; i < 2; i++) begin
            i_valid = 1'b1; i_data = 4'($urandom); i_last = 1'b0;
            i_mode = 1'b0; i_poly = 3'b111; i_init = 2'b00;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        check("rst_mid_valid", o_valid, 0);
        run_frame(1, CRC_GEN, 3'b111, 2'b00, 1'b1, 1'b1, 0);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            int n;
            bit lst;
            n   = $urandom_range(1, MAXB);
            lst = (n < MAXB) ? 1'b1 : 1'($urandom);
            for (int i = 0; i < n; i++) fdata[i] = 4'($urandom);
            run_frame(n, 1'($urandom), 3'($urandom), 2'($urandom), 1'($urandom),
                      lst, $urandom_range(0, 2));
        end

        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        check("drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
